// File: rtl/lc3_pkg.sv
// Shared LC-3 memory/IO definitions: device addresses, read-mux encodings, FSM states
// and the address decoder used by mem_io_ctrl.
package lc3_pkg;

   localparam logic [15:0] AddrKbsr = 16'hFE00;
   localparam logic [15:0] AddrKbdr = 16'hFE02;
   localparam logic [15:0] AddrDsr  = 16'hFE04;
   localparam logic [15:0] AddrDdr  = 16'hFE06;

   typedef enum logic [1:0] {
      SelKbdr = 2'b00,
      SelKbsr = 2'b01,
      SelDsr  = 2'b10,
      SelMem  = 2'b11
   } inmux_sel_e;

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StMemAcc = 2'b01,
      StDone   = 2'b10
   } state_e;

   typedef enum logic [2:0] {
      DevMem  = 3'd0,
      DevKbsr = 3'd1,
      DevKbdr = 3'd2,
      DevDsr  = 3'd3,
      DevDdr  = 3'd4
   } dev_e;

   function automatic dev_e decode_addr(input logic [15:0] addr);
      dev_e dev;
      case (addr)
         AddrKbsr: dev = DevKbsr;
         AddrKbdr: dev = DevKbdr;
         AddrDsr:  dev = DevDsr;
         AddrDdr:  dev = DevDdr;
         default:  dev = DevMem;
      endcase
      return dev;
   endfunction

   // DDR is write-only, so it reads through the memory leg of the mux.
   function automatic inmux_sel_e dev_sel(input dev_e dev);
      inmux_sel_e sel;
      case (dev)
         DevKbdr: sel = SelKbdr;
         DevKbsr: sel = SelKbsr;
         DevDsr:  sel = SelDsr;
         default: sel = SelMem;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/mem_io_ctrl_if.sv
// Bus between the control FSM / memory / keyboard / display and mem_io_ctrl.
// KBD_INT exists only when KBD_INT_EN is defined.
interface mem_io_ctrl_if;
   logic        MEM_EN;
   logic        R_W;
   logic [15:0] MAR;
   logic [15:0] MDR_IN;
   logic        R;
   logic [1:0]  INMUX_SEL;
   logic        MEM_CE;
   logic        MEM_WE;
   logic        KBD_VALID;
   logic [7:0]  KBD_DATA;
   logic [15:0] KBDR_OUT;
   logic [15:0] KBSR_OUT;
   logic [15:0] DSR_OUT;
   logic        DDR_VALID;
   logic [7:0]  DDR_DATA;
   logic        DISP_ACK;
`ifdef KBD_INT_EN
   logic        KBD_INT;
`endif

   modport slave (
      input  MEM_EN, R_W, MAR, MDR_IN, KBD_VALID, KBD_DATA, DISP_ACK,
      output R, INMUX_SEL, MEM_CE, MEM_WE, KBDR_OUT, KBSR_OUT, DSR_OUT, DDR_VALID, DDR_DATA
`ifdef KBD_INT_EN
      , output KBD_INT
`endif
   );

   modport master (
      output MEM_EN, R_W, MAR, MDR_IN, KBD_VALID, KBD_DATA, DISP_ACK,
      input  R, INMUX_SEL, MEM_CE, MEM_WE, KBDR_OUT, KBSR_OUT, DSR_OUT, DDR_VALID, DDR_DATA
`ifdef KBD_INT_EN
      , input KBD_INT
`endif
   );

endinterface

// File: rtl/io_dev_regs.sv
// Keyboard (KBSR/KBDR) and display (DSR/DDR) register set.
// KBD_INT_EN adds a writable KBSR[14] interrupt enable and a registered kbd_int.
module io_dev_regs (
   input  logic        clk,
   input  logic        rst,
   input  logic        kbd_valid,
   input  logic [7:0]  kbd_data,
   input  logic        rd_kbdr,
   input  logic        wr_ddr,
   input  logic [7:0]  ddr_wdata,
`ifdef KBD_INT_EN
   input  logic        wr_kbsr,
   input  logic        ie_wdata,
   output logic        kbd_int,
`endif
   input  logic        disp_ack,
   output logic [15:0] kbdr,
   output logic [15:0] kbsr,
   output logic [15:0] dsr,
   output logic        ddr_valid,
   output logic [7:0]  ddr_data
);

   logic [7:0] kbdr_q;
   logic       kbd_ready_q;
   logic       dsr_ready_q;
   logic       ddr_valid_q;
   logic [7:0] ddr_data_q;
   logic       ie;

   // A new character beats a same-cycle KBDR read, so ready stays set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kbdr_q      <= 8'h00;
         kbd_ready_q <= 1'b0;
      end else if (kbd_valid) begin
         kbdr_q      <= kbd_data;
         kbd_ready_q <= 1'b1;
      end else if (rd_kbdr) begin
         kbd_ready_q <= 1'b0;
      end
   end

   // Writes while the display is busy are dropped; ACK is only honoured while busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dsr_ready_q <= 1'b1;
         ddr_valid_q <= 1'b0;
         ddr_data_q  <= 8'h00;
      end else if (wr_ddr && dsr_ready_q) begin
         dsr_ready_q <= 1'b0;
         ddr_valid_q <= 1'b1;
         ddr_data_q  <= ddr_wdata;
      end else if (disp_ack && ddr_valid_q) begin
         dsr_ready_q <= 1'b1;
         ddr_valid_q <= 1'b0;
      end
   end

`ifdef KBD_INT_EN
   logic ie_q;
   logic kbd_int_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ie_q      <= 1'b0;
         kbd_int_q <= 1'b0;
      end else begin
         if (wr_kbsr) ie_q <= ie_wdata;
         kbd_int_q <= kbd_ready_q & ie_q;
      end
   end

   assign ie      = ie_q;
   assign kbd_int = kbd_int_q;
`else
   assign ie = 1'b0;
`endif

   assign kbdr      = {8'h00, kbdr_q};
   assign kbsr      = {kbd_ready_q, ie, 14'h0000};
   assign dsr       = {dsr_ready_q, 15'h0000};
   assign ddr_valid = ddr_valid_q;
   assign ddr_data  = ddr_data_q;

endmodule

// File: rtl/mem_io_ctrl.sv
// LC-3 memory/IO access controller: address decode, access FSM and read-mux select.
// Optional keyboard interrupt output is enabled by defining KBD_INT_EN.
module mem_io_ctrl
   import lc3_pkg::*;
#(
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic         CLK,
   input  logic         RESET,
   mem_io_ctrl_if.slave bus
);

   localparam logic [3:0] LastCnt = 4'(MEM_LATENCY - 1);

   state_e     state_q, state_d;
   dev_e       dev_q;
   logic       rw_q;
   logic [7:0] wdata_q;
   logic [3:0] cnt_q;
   logic       accept;
   logic       done;

   assign accept = (state_q == StIdle) && bus.MEM_EN;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (bus.MEM_EN) begin
               state_d = (decode_addr(bus.MAR) == DevMem) ? StMemAcc : StDone;
            end
         end
         StMemAcc: if (cnt_q == LastCnt) state_d = StDone;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      done          = (state_q == StDone);
      bus.R         = done;
      bus.MEM_CE    = (state_q == StMemAcc);
      bus.MEM_WE    = (state_q == StMemAcc) && rw_q;
      bus.INMUX_SEL = (state_q == StIdle) ? SelMem : dev_sel(dev_q);
   end

   // Request fields are captured once at acceptance and held for the whole access.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         dev_q   <= DevMem;
         rw_q    <= 1'b0;
         wdata_q <= 8'h00;
      end else if (accept) begin
         dev_q   <= decode_addr(bus.MAR);
         rw_q    <= bus.R_W;
         wdata_q <= bus.MDR_IN[7:0];
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)                      cnt_q <= 4'd0;
      else if (state_q == StMemAcc)   cnt_q <= cnt_q + 4'd1;
      else                            cnt_q <= 4'd0;
   end

`ifdef KBD_INT_EN
   logic ie_wdata_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)       ie_wdata_q <= 1'b0;
      else if (accept) ie_wdata_q <= bus.MDR_IN[14];
   end
`endif

   io_dev_regs u_io_dev_regs (
      .clk       (CLK),
      .rst       (RESET),
      .kbd_valid (bus.KBD_VALID),
      .kbd_data  (bus.KBD_DATA),
      .rd_kbdr   (done && !rw_q && (dev_q == DevKbdr)),
      .wr_ddr    (done && rw_q && (dev_q == DevDdr)),
      .ddr_wdata (wdata_q),
`ifdef KBD_INT_EN
      .wr_kbsr   (done && rw_q && (dev_q == DevKbsr)),
      .ie_wdata  (ie_wdata_q),
      .kbd_int   (bus.KBD_INT),
`endif
      .disp_ack  (bus.DISP_ACK),
      .kbdr      (bus.KBDR_OUT),
      .kbsr      (bus.KBSR_OUT),
      .dsr       (bus.DSR_OUT),
      .ddr_valid (bus.DDR_VALID),
      .ddr_data  (bus.DDR_DATA)
   );

endmodule

// File: doc/mem_io_ctrl.md
MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

Interface
- REQ-001 SHALL have parameter MEM_LATENCY, default 2, meaning memory access cycles, legal range 1..15.
- REQ-002 SHALL have one clock; reset is asynchronous and active-high.
- REQ-003 SHALL have port CLK, input, 1 bit: rising-edge clock.
- REQ-004 SHALL have port RESET, input, 1 bit: asynchronous active-high reset.
- REQ-005 SHALL have port MEM_EN, input, 1 bit: access request from the control FSM.
- REQ-006 SHALL have port R_W, input, 1 bit: 1 is write, 0 is read.
- REQ-007 SHALL have port MAR, input, 16 bits: access address.
- REQ-008 SHALL have port MDR_IN, input, 16 bits: write data.
- REQ-009 SHALL have port R, output, 1 bit: access-complete pulse.
- REQ-010 SHALL have port INMUX_SEL, output, 2 bits: read source, where 00 is KBDR, 01 is KBSR, 10 is DSR and 11 is MEM.
- REQ-011 SHALL have ports MEM_CE (output, 1 bit) and MEM_WE (output, 1 bit): memory strobes.
- REQ-012 SHALL have ports KBD_VALID (input, 1 bit) and KBD_DATA (input, 8 bits): keyboard character strobe and data.
- REQ-013 SHALL have ports KBDR_OUT, KBSR_OUT and DSR_OUT, each output, 16 bits: device register values.
- REQ-014 SHALL have ports DDR_VALID (output, 1 bit), DDR_DATA (output, 8 bits) and DISP_ACK (input, 1 bit): display handshake.
- REQ-015 SHALL have port KBD_INT, output, 1 bit: keyboard interrupt request; the port exists only with KBD_INT_EN.

Function
- REQ-016 SHALL decode the address map as follows: 0xFE00 is KBSR, 0xFE02 is KBDR, 0xFE04 is DSR, 0xFE06 is DDR, and every other address is MEM.
- REQ-017 SHALL use an FSM with states IDLE, MEM_ACC and DONE; a request SHALL be sampled only in IDLE with MEM_EN=1.
- REQ-018 SHALL, for a MEM access, go IDLE->MEM_ACC, hold MEM_CE=1 (and MEM_WE=R_W) for exactly MEM_LATENCY cycles, then go to DONE.
- REQ-019 SHALL, for a device access, go IDLE->DONE directly; device latency is 1 cycle.
- REQ-020 SHALL assert R for exactly one cycle in DONE and then return to IDLE; with MEM_EN still 1, a new access SHALL begin on the next cycle.
- REQ-021 SHALL hold INMUX_SEL, decoded from the latched MAR, from acceptance through DONE, and SHALL drive 11 in IDLE.
- REQ-022 SHALL latch MAR and R_W at acceptance; later changes during the access SHALL be ignored.
- REQ-023 SHALL, on KBD_VALID, load KBDR[7:0]=KBD_DATA and set KBSR[15]; a later character SHALL overwrite KBDR (overrun, no error flag).
- REQ-024 SHALL clear KBSR[15] when a KBDR read completes (R=1); if KBD_VALID occurs in the same cycle, the new character wins and KBSR[15] stays 1.
- REQ-025 SHALL make only KBSR[14] (IE) writable; all other KBSR bits and KBDR SHALL be read-only.
- REQ-026 SHALL, on a DDR write with DSR[15]=1, set DDR_DATA=MDR_IN[7:0], DDR_VALID=1 and DSR[15]=0; a DDR write with DSR[15]=0 SHALL be dropped but still complete with R.
- REQ-027 SHALL, on DISP_ACK while DDR_VALID=1, clear DDR_VALID and set DSR[15]; DISP_ACK with DDR_VALID=0 SHALL be ignored.
- REQ-028 SHALL read zero from all unused register bits.

Reset
- REQ-029 SHALL, on RESET, immediately set the FSM to IDLE and drive R=0, MEM_CE=0, MEM_WE=0, INMUX_SEL=11, KBDR_OUT=0, KBSR_OUT=0, DSR_OUT=0x8000, DDR_VALID=0, DDR_DATA=0 and KBD_INT=0.
- REQ-030 SHALL abort any access in progress on RESET without asserting R.

Configuration
- REQ-031 SHALL, with KBD_INT_EN defined, drive KBD_INT = KBSR[15] & KBSR[14], registered, with 1-cycle latency.
- REQ-032 SHALL, without KBD_INT_EN, omit the KBD_INT port, and KBSR[14] SHALL be a read-only zero.

Structure
- REQ-033 SHALL place the device addresses, the INMUX_SEL encodings and the FSM state encoding in the shared package lc3_pkg.
- REQ-034 SHALL implement the keyboard/display register set as the sub-module io_dev_regs; the FSM and decode SHALL stay in the top module.

Verification
- REQ-035 SHALL cover: MEM read 0x3000 with MEM_LATENCY=2 -> MEM_CE high 2 cycles, R on cycle 3, INMUX_SEL=11.
- REQ-036 SHALL cover: KBD_VALID with KBD_DATA=0x41, then KBDR read -> KBDR_OUT=0x0041, KBSR[15] 1 then 0 after R.
- REQ-037 SHALL cover: DDR write 0x0058 -> DDR_VALID=1, DDR_DATA=0x58, DSR=0x0000; then DISP_ACK -> DSR=0x8000.
- REQ-038 SHALL cover: RESET during cycle 1 of MEM_ACC -> no R pulse, all outputs at reset values, next access normal.
- REQ-039 SHALL cover: KBD_VALID in the same cycle as KBDR read completion -> KBSR[15] remains 1, KBDR holds the new character.
- REQ-040 SHALL cover, with KBD_INT_EN: write KBSR=0x4000, then a keystroke -> KBD_INT=1 one cycle after KBSR[15] sets.
